// File: rtl/audio_pkg.sv
// Shared audio types for the DAC feeder path.
// Sample/frame types, counter sizing and the load-time attenuator.
package audio_pkg;

    localparam int CHANNEL_LENGTH = 16;
    localparam int CNT_W          = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    typedef logic signed [CHANNEL_LENGTH-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    typedef enum logic {
        HALF_LEFT  = 1'b0,
        HALF_RIGHT = 1'b1
    } half_e;

    function automatic sample_t atten_shift(sample_t s, logic [3:0] a);
        return s >>> a;
    endfunction

endpackage

// File: rtl/dac_sample_feeder_if.sv
// Upstream frame handshake into the DAC feeder.
// master = synth/mixer side, slave = feeder side.
interface dac_sample_feeder_if;
    import audio_pkg::*;

    logic    i_valid;
    logic    o_ready;
    sample_t i_left;
    sample_t i_right;

    modport master (
        output i_valid,
        output i_left,
        output i_right,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_left,
        input  i_right,
        output o_ready
    );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO; pointers carry one extra bit so full/empty
// differ only in the wrap bit.
module sample_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;
    T            mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers stereo frames and presents one attenuated sample per
// lrck half, stable across the serializer's shift window.
module dac_sample_feeder
    import audio_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SWITCH_AT     = 20,
    parameter int UNDERRUN_HOLD = 0
) (
    input  logic                    i_bclk,
    input  logic                    i_rst,
    input  logic                    i_daclrck,
    dac_sample_feeder_if.slave      up,
    input  logic [3:0]              i_atten,
    input  logic                    i_clr_underrun,
    output sample_t                 o_sound,
    output logic                    o_underrun,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam logic [CNT_W-1:0] LOAD_AT = CNT_W'(SWITCH_AT - 1);

    half_e            half_q;
    half_e            half_d;
    logic [CNT_W-1:0] cnt;
    logic             lr_edge;
    logic             load;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             under_set;
    stereo_t          head;
    stereo_t          last_q;
    stereo_t          frame;
    stereo_t          din;
    sample_t          held_right;
    sample_t          held_d;
    sample_t          sound_d;

    assign din        = '{l: up.i_left, r: up.i_right};
    assign up.o_ready = !full;
    assign push       = up.i_valid && !full;
    assign lr_edge    = (half_e'(i_daclrck) != half_q);
    assign load       = !lr_edge && (cnt == LOAD_AT);

    sample_fifo #(
        .DEPTH (DEPTH),
        .T     (stereo_t)
    ) u_fifo (
        .clk   (i_bclk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (o_level)
    );

    // Right-half load feeds the next left window, left-half load the
    // next right window from the half-frame parked in held_right.
    always_comb begin
        half_d    = half_e'(i_daclrck);
        pop       = 1'b0;
        under_set = 1'b0;
        frame     = head;
        sound_d   = o_sound;
        held_d    = held_right;
        if (load) begin
            unique case (half_q)
                HALF_RIGHT: begin
                    pop       = !empty;
                    under_set = empty;
                    if (empty) begin
                        frame = (UNDERRUN_HOLD != 0) ? last_q : '0;
                    end
                    sound_d = atten_shift(frame.l, i_atten);
                    held_d  = frame.r;
                end
                HALF_LEFT: begin
                    sound_d = atten_shift(held_right, i_atten);
                end
            endcase
        end
    end

    always_ff @(posedge i_bclk or posedge i_rst) begin
        if (i_rst) begin
            half_q     <= HALF_LEFT;
            cnt        <= '0;
            o_sound    <= '0;
            held_right <= '0;
            last_q     <= '0;
            o_underrun <= 1'b0;
        end else begin
            half_q     <= half_d;
            o_sound    <= sound_d;
            held_right <= held_d;
            if (lr_edge) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (pop) begin
                last_q <= head;
            end
            if (under_set) begin
                o_underrun <= 1'b1;
            end else if (i_clr_underrun) begin
                o_underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Randomized scoreboard bench for dac_sample_feeder.
// Model: frame queue, load SWITCH_AT bclks after each lrck edge.
module tb_dac_sample_feeder;
    import audio_pkg::*;

    localparam int DEPTH = 4;
    localparam int SW    = 20;
    localparam int HOLD  = 0;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       lrck  = 1'b0;
    logic [3:0] atten = '0;
    logic       clr   = 1'b0;
    sample_t    sound;
    logic       under;
    logic [2:0] level;

    dac_sample_feeder_if fif();

    dac_sample_feeder #(
        .DEPTH         (DEPTH),
        .SWITCH_AT     (SW),
        .UNDERRUN_HOLD (HOLD)
    ) dut (
        .i_bclk         (clk),
        .i_rst          (rst),
        .i_daclrck      (lrck),
        .up             (fif),
        .i_atten        (atten),
        .i_clr_underrun (clr),
        .o_sound        (sound),
        .o_underrun     (under),
        .o_level        (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int      tag;
        sample_t snd;
        logic    und;
        int      lvl;
        logic    rdy;
    } exp_t;

    exp_t    expq[$];
    stereo_t mq[$];
    stereo_t dir_q[$];
    stereo_t m_last;
    sample_t m_held;
    sample_t m_sound;
    logic    m_under;
    int      push_pct  = 0;
    int      clr_pct   = 0;
    int      atten_fix = 0;

    function automatic void chk(string nm, logic signed [31:0] act,
                                logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    // Floor division by 2**a in plain integer arithmetic.
    function automatic sample_t shr(sample_t v, int a);
        int x;
        int d;
        int r;
        x = v;
        d = 1 << a;
        if (x >= 0) r = x / d;
        else        r = -((-x + d - 1) / d);
        return r[15:0];
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_last  = '0;
        m_held  = '0;
        m_sound = '0;
        m_under = 1'b0;
    endfunction

    task automatic step(input bit lv, input bit ld);
        int      tag;
        bit      acc;
        bit      und_new;
        bit      v;
        stereo_t d;
        stereo_t f;
        @(negedge clk);
        lrck = lv;
        if (dir_q.size() > 0) begin
            v = 1'b1;
            d = dir_q[0];
        end else begin
            v   = ($urandom_range(99) < push_pct);
            d.l = sample_t'($urandom);
            d.r = sample_t'($urandom);
        end
        fif.i_valid = v;
        fif.i_left  = d.l;
        fif.i_right = d.r;
        atten = (atten_fix < 0) ? 4'($urandom_range(15)) : 4'(atten_fix);
        clr   = ($urandom_range(99) < clr_pct);
        tag   = cyc + 1;
        acc   = v && (mq.size() < DEPTH);
        @(posedge clk);
        und_new = 1'b0;
        if (ld) begin
            if (lv) begin
                if (mq.size() > 0) begin
                    f      = mq.pop_front();
                    m_last = f;
                end else begin
                    und_new = 1'b1;
                    f       = (HOLD != 0) ? m_last : '0;
                end
                m_sound = shr(f.l, int'(atten));
                m_held  = f.r;
            end else begin
                m_sound = shr(m_held, int'(atten));
            end
        end
        if (acc) begin
            mq.push_back(d);
            if (dir_q.size() > 0) void'(dir_q.pop_front());
        end
        if (und_new)  m_under = 1'b1;
        else if (clr) m_under = 1'b0;
        expq.push_back('{tag: tag, snd: m_sound, und: m_under,
                         lvl: mq.size(), rdy: (mq.size() < DEPTH)});
    endtask

    task automatic run_half(input bit lv, input int h);
        for (int k = 0; k < h; k++) step(lv, k == SW);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fif.i_valid = 1'b0;
        clr = 1'b0;
        #1;
        model_reset();
        chk("rst_level", level, 0);
        chk("rst_sound", sound, 0);
        chk("rst_underrun", under, 0);
        chk("rst_ready", fif.o_ready, 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (expq.size() > 0 && expq[0].tag < cyc) begin
                chk("exp_skipped", expq[0].tag, cyc);
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].tag == cyc) begin
                e = expq.pop_front();
                chk("sound", sound, e.snd);
                chk("underrun", under, e.und);
                chk("level", level, e.lvl);
                chk("ready", fif.o_ready, e.rdy);
            end
        end
    end

    initial begin : stimulus
        bit lv;
        int h;
        fif.i_valid = 1'b0;
        fif.i_left  = '0;
        fif.i_right = '0;
        model_reset();
        do_reset();

        atten_fix = 0;
        dir_q.push_back('{l: 16'h1234, r: 16'hF00D});
        dir_q.push_back('{l: 16'h0001, r: 16'h0002});
        run_half(1'b0, 16);
        run_half(1'b1, 32);
        run_half(1'b0, 32);
        run_half(1'b1, 32);

        run_half(1'b0, 32);
        run_half(1'b1, 32);
        run_half(1'b0, 32);
        clr_pct = 100;
        run_half(1'b1, 16);
        clr_pct = 0;

        dir_q.push_back('{l: 16'h8000, r: 16'h7FFF});
        dir_q.push_back('{l: 16'hFFFF, r: 16'hFFFF});
        run_half(1'b0, 32);
        atten_fix = 15;
        run_half(1'b1, 32);
        atten_fix = 1;
        run_half(1'b0, 32);
        run_half(1'b1, 32);
        run_half(1'b0, 32);

        atten_fix = -1;
        push_pct  = 100;
        run_half(1'b1, 40);
        push_pct  = 0;
        run_half(1'b0, 32);

        run_half(1'b1, 11);
        do_reset();
        run_half(1'b1, 32);

        push_pct = 50;
        for (int i = 0; i < 6; i++) begin
            run_half(1'b0, 16);
            run_half(1'b1, 16);
        end

        lv = 1'b1;
        for (int i = 0; i < 60; i++) begin
            lv = !lv;
            h  = $urandom_range(16, 48);
            if (h == 20) h = 21;
            if (i == 30) h = 300;
            push_pct = $urandom_range(20, 90);
            clr_pct  = $urandom_range(0, 10);
            run_half(lv, h);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("exp_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
